// File: rtl/pcie_cpl_tx_if.sv
// Request-side handshake plus TRN transmit bus of the completion generator.
// The slave modport is the completion generator; the master modport is its environment.
interface pcie_cpl_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [6:0]  req_lower_addr;
    logic        req_len2;
    logic [63:0] req_data;

    logic        trn_lnk_up_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tdst_rdy_n;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;
    logic        trn_tstr_n;

    modport master (
        output req_valid, req_rid, req_tag, req_tc, req_attr, req_lower_addr, req_len2, req_data,
        output trn_lnk_up_n, trn_tbuf_av, trn_tdst_rdy_n,
        input  req_ready, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n
    );

    modport slave (
        input  req_valid, req_rid, req_tag, req_tc, req_attr, req_lower_addr, req_len2, req_data,
        input  trn_lnk_up_n, trn_tbuf_av, trn_tdst_rdy_n,
        output req_ready, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n
    );
endinterface

// File: rtl/pcie_cpl_tx.sv
// Builds a CplD TLP (1 or 2 data DWs) for an accepted read request and streams it
// on the 64-bit TRN transmit bus; aborts on link loss.
module pcie_cpl_tx (
    input  logic         trn_clk,
    input  logic         trn_reset,
    input  logic [7:0]   cfg_bus_number,
    input  logic [4:0]   cfg_device_number,
    input  logic [2:0]   cfg_function_number,
    pcie_cpl_tx_if.slave bus,
    output logic [15:0]  cpl_count,
    output logic [7:0]   abort_count
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, BEAT2} state_e;

    state_e      state_q, state_d;
    logic [63:0] td_q, td_d;
    logic        sof_n_q, sof_n_d;
    logic        eof_n_q, eof_n_d;
    logic        trem_n_q, trem_n_d;
    logic        src_rdy_n_q, src_rdy_n_d;
    logic [31:0] dw2_q, dw2_d;
    logic [63:0] data_q, data_d;
    logic        len2_q, len2_d;
    logic [15:0] cpl_q, cpl_d;
    logic [7:0]  abort_q, abort_d;

    logic        accept;
    logic        eop;
    logic [15:0] cpl_id;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;

    // Gating with reset keeps the request side closed while the block is held in reset.
    assign bus.req_ready = !trn_reset && (state_q == IDLE) && !bus.trn_lnk_up_n
                           && (bus.trn_tbuf_av != 6'd0);
    assign accept  = bus.req_valid && bus.req_ready;

    assign cpl_id  = {cfg_bus_number, cfg_device_number, cfg_function_number};
    assign hdr_dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, bus.req_tc, 4'b0000, 1'b0, 1'b0,
                      bus.req_attr, 2'b00, bus.req_len2 ? 10'd2 : 10'd1};
    assign hdr_dw1 = {cpl_id, 3'b000, 1'b0, bus.req_len2 ? 12'd8 : 12'd4};

    always_ff @(posedge trn_clk or posedge trn_reset) begin
        if (trn_reset) begin
            state_q     <= IDLE;
            td_q        <= '0;
            sof_n_q     <= 1'b1;
            eof_n_q     <= 1'b1;
            trem_n_q    <= 1'b0;
            src_rdy_n_q <= 1'b1;
            dw2_q       <= '0;
            data_q      <= '0;
            len2_q      <= 1'b0;
            cpl_q       <= '0;
            abort_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            td_q        <= td_d;
            sof_n_q     <= sof_n_d;
            eof_n_q     <= eof_n_d;
            trem_n_q    <= trem_n_d;
            src_rdy_n_q <= src_rdy_n_d;
            dw2_q       <= dw2_d;
            data_q      <= data_d;
            len2_q      <= len2_d;
            cpl_q       <= cpl_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no latch can be inferred.
        state_d     = state_q;
        td_d        = td_q;
        sof_n_d     = sof_n_q;
        eof_n_d     = eof_n_q;
        trem_n_d    = trem_n_q;
        src_rdy_n_d = src_rdy_n_q;
        dw2_d       = dw2_q;
        data_d      = data_q;
        len2_d      = len2_q;
        cpl_d       = cpl_q;
        abort_d     = abort_q;
        eop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = BEAT0;
                    td_d        = {hdr_dw0, hdr_dw1};
                    sof_n_d     = 1'b0;
                    eof_n_d     = 1'b1;
                    trem_n_d    = 1'b0;
                    src_rdy_n_d = 1'b0;
                    dw2_d       = {bus.req_rid, bus.req_tag, 1'b0, bus.req_lower_addr};
                    data_d      = bus.req_data;
                    len2_d      = bus.req_len2;
                end
            end
            default: begin
                // Link loss wins over a beat accepted in the same cycle.
                if (bus.trn_lnk_up_n) begin
                    state_d     = IDLE;
                    src_rdy_n_d = 1'b1;
                    sof_n_d     = 1'b1;
                    eof_n_d     = 1'b1;
                    if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                end else if (!bus.trn_tdst_rdy_n) begin
                    sof_n_d = 1'b1;
                    case (state_q)
                        BEAT0: begin
                            state_d  = BEAT1;
                            td_d     = {dw2_q, data_q[31:0]};
                            eof_n_d  = len2_q;
                            trem_n_d = 1'b0;
                        end
                        BEAT1: begin
                            if (len2_q) begin
                                state_d  = BEAT2;
                                td_d     = {data_q[63:32], 32'h0};
                                eof_n_d  = 1'b0;
                                trem_n_d = 1'b1;
                            end else begin
                                eop = 1'b1;
                            end
                        end
                        default: eop = 1'b1;
                    endcase
                    if (eop) begin
                        state_d     = IDLE;
                        src_rdy_n_d = 1'b1;
                        eof_n_d     = 1'b1;
                        cpl_d       = cpl_q + 16'd1;
                    end
                end
            end
        endcase
    end

    assign bus.trn_td         = td_q;
    assign bus.trn_tsof_n     = sof_n_q;
    assign bus.trn_teof_n     = eof_n_q;
    assign bus.trn_trem_n     = trem_n_q;
    assign bus.trn_tsrc_rdy_n = src_rdy_n_q;
    assign bus.trn_tsrc_dsc_n = 1'b1;
    assign bus.trn_terrfwd_n  = 1'b1;
    assign bus.trn_tstr_n     = 1'b1;
    assign cpl_count          = cpl_q;
    assign abort_count        = abort_q;
endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Self-checking bench for pcie_cpl_tx: directed cases plus randomized packets checked
// against a beat-list model built straight from the TLP field layout.
module tb_pcie_cpl_tx;
    typedef struct packed {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic        trem_n;
    } beat_t;

    logic        trn_clk = 1'b0;
    logic        trn_reset;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  fn_num;
    logic [15:0] cpl_count;
    logic [7:0]  abort_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_cpl = 0;
    int          exp_abort = 0;
    logic [63:0] obs_beat [3];

    pcie_cpl_tx_if bus_if ();

    pcie_cpl_tx dut (
        .trn_clk             (trn_clk),
        .trn_reset           (trn_reset),
        .cfg_bus_number      (bus_num),
        .cfg_device_number   (dev_num),
        .cfg_function_number (fn_num),
        .bus                 (bus_if),
        .cpl_count           (cpl_count),
        .abort_count         (abort_count)
    );

    always #5 trn_clk = ~trn_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request and return at posedge+1 of the first cycle after it was accepted.
    task automatic start_req(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                             input logic [1:0] attr, input logic [6:0] la, input logic len2,
                             input logic [63:0] data);
        int n = 0;
        @(posedge trn_clk); #1;
        bus_if.req_rid        = rid;
        bus_if.req_tag        = tag;
        bus_if.req_tc         = tc;
        bus_if.req_attr       = attr;
        bus_if.req_lower_addr = la;
        bus_if.req_len2       = len2;
        bus_if.req_data       = data;
        bus_if.req_valid      = 1'b1;
        @(negedge trn_clk);
        while (!bus_if.req_ready && n < 20) begin
            @(negedge trn_clk);
            n++;
        end
        check("req_ready_wait", bus_if.req_ready, 1'b1);
        @(posedge trn_clk); #1;
        bus_if.req_valid = 1'b0;
    endtask

    // stall_mode: 0 = sink always ready, 1 = random stalls, 2 = five stall cycles on beat 1.
    task automatic run_pkt(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                           input logic [1:0] attr, input logic [6:0] la, input logic len2,
                           input logic [63:0] data, input int stall_mode, input bit drop_tbuf);
        beat_t       q[$];
        logic [31:0] dw0, dw1, dw2;
        int          idx = 0;
        int          cyc = 0;
        int          stall_left = 5;
        logic        stall;
        dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, len2 ? 10'd2 : 10'd1};
        dw1 = {bus_num, dev_num, fn_num, 3'b000, 1'b0, len2 ? 12'd8 : 12'd4};
        dw2 = {rid, tag, 1'b0, la};
        q.push_back('{td: {dw0, dw1}, sof_n: 1'b0, eof_n: 1'b1, trem_n: 1'b0});
        q.push_back('{td: {dw2, data[31:0]}, sof_n: 1'b1, eof_n: len2, trem_n: 1'b0});
        if (len2) q.push_back('{td: {data[63:32], 32'h0}, sof_n: 1'b1, eof_n: 1'b0, trem_n: 1'b1});

        bus_if.trn_tdst_rdy_n = 1'b0;
        start_req(rid, tag, tc, attr, la, len2, data);
        if (drop_tbuf) bus_if.trn_tbuf_av = 6'd0;
        while (idx < q.size() && cyc < 200) begin
            case (stall_mode)
                0: stall = 1'b0;
                1: stall = ($urandom_range(0, 2) == 0);
                default: begin
                    stall = (idx == 1 && stall_left > 0);
                    if (stall) stall_left--;
                end
            endcase
            bus_if.trn_tdst_rdy_n = stall;
            @(negedge trn_clk);
            check("beat_vec",
                  {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n, bus_if.trn_teof_n, bus_if.trn_trem_n, bus_if.trn_td},
                  {1'b0, q[idx].sof_n, q[idx].eof_n, q[idx].trem_n, q[idx].td});
            if (!stall) begin
                obs_beat[idx] = bus_if.trn_td;
                idx++;
            end
            @(posedge trn_clk); #1;
            cyc++;
        end
        check("pkt_beats_done", idx, q.size());
        bus_if.trn_tdst_rdy_n = 1'b0;
        exp_cpl = (exp_cpl + 1) % 65536;
        @(negedge trn_clk);
        check("idle_flags", {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n, bus_if.trn_teof_n}, 3'b111);
        check("idle_td_hold", bus_if.trn_td, q[q.size()-1].td);
        check("cpl_count", cpl_count, exp_cpl[15:0]);
    endtask

    initial begin
        trn_reset             = 1'b1;
        bus_num               = 8'h01;
        dev_num               = 5'd0;
        fn_num                = 3'd0;
        bus_if.trn_lnk_up_n   = 1'b0;
        bus_if.trn_tbuf_av    = 6'h3F;
        bus_if.trn_tdst_rdy_n = 1'b0;
        bus_if.req_valid      = 1'b1;
        bus_if.req_rid        = '0;
        bus_if.req_tag        = '0;
        bus_if.req_tc         = '0;
        bus_if.req_attr       = '0;
        bus_if.req_lower_addr = '0;
        bus_if.req_len2       = 1'b0;
        bus_if.req_data       = '0;

        // Reset state, with a request pending to show the handshake stays closed.
        repeat (2) @(negedge trn_clk);
        check("rst_vec",
              {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n, bus_if.trn_teof_n, bus_if.trn_trem_n, bus_if.trn_td},
              {1'b1, 1'b1, 1'b1, 1'b0, 64'h0});
        check("rst_counters", {cpl_count, abort_count}, 24'h0);
        check("rst_req_ready", bus_if.req_ready, 1'b0);
        check("rst_const", {bus_if.trn_tsrc_dsc_n, bus_if.trn_terrfwd_n, bus_if.trn_tstr_n}, 3'b111);
        bus_if.req_valid = 1'b0;
        @(posedge trn_clk); #1;
        trn_reset = 1'b0;

        // 1-DW completion with known header.
        run_pkt(16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 1'b0, {32'h0, 32'hDEADBEEF}, 0, 1'b0);
        check("d1_beat0", obs_beat[0], 64'h4A000001_01000004);
        check("d1_beat1", obs_beat[1], 64'h01000504_DEADBEEF);
        check("d1_cpl", cpl_count, 16'd1);

        // 2-DW completion.
        run_pkt(16'h0100, 8'h06, 3'd0, 2'd0, 7'h08, 1'b1, 64'h11112222_33334444, 0, 1'b0);
        check("d2_length", obs_beat[0][41:32], 10'd2);
        check("d2_bytecnt", obs_beat[0][11:0], 12'd8);
        check("d2_beat1_lo", obs_beat[1][31:0], 32'h33334444);
        check("d2_beat2", obs_beat[2], 64'h11112222_00000000);

        // Five-cycle stall on beat 1: each stalled cycle re-checks the held beat.
        run_pkt(16'hBEEF, 8'h77, 3'd5, 2'd3, 7'h7F, 1'b1, 64'hCAFEF00D_12345678, 2, 1'b0);

        // Link loss in BEAT1 together with an accepted beat: abort must win.
        bus_if.trn_tdst_rdy_n = 1'b0;
        start_req(16'h1234, 8'h01, 3'd1, 2'd1, 7'h10, 1'b1, 64'hAAAA5555_0F0F0F0F);
        @(negedge trn_clk);
        check("ld_beat0_sof", {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n}, 2'b00);
        @(posedge trn_clk); #1;
        bus_if.trn_lnk_up_n = 1'b1;
        @(posedge trn_clk); #1;
        exp_abort++;
        @(negedge trn_clk);
        check("ld_idle_flags", {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n, bus_if.trn_teof_n}, 3'b111);
        check("ld_abort", abort_count, exp_abort[7:0]);
        check("ld_cpl_same", cpl_count, exp_cpl[15:0]);
        check("ld_req_ready", bus_if.req_ready, 1'b0);
        bus_if.trn_lnk_up_n = 1'b0;

        // No buffers: request must wait; then one buffer, and dropping it mid-packet must not stall.
        @(posedge trn_clk); #1;
        bus_if.trn_tbuf_av = 6'd0;
        bus_if.req_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge trn_clk);
            check("tbuf0_blocked", {bus_if.req_ready, bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n}, 3'b011);
        end
        bus_if.req_valid   = 1'b0;
        bus_if.trn_tbuf_av = 6'h01;
        run_pkt(16'h0042, 8'hA5, 3'd2, 2'd2, 7'h2C, 1'b1, 64'h01234567_89ABCDEF, 1, 1'b1);
        bus_if.trn_tbuf_av = 6'h3F;

        // Randomized packets with random sink stalls.
        for (int i = 0; i < 20; i++) begin
            bus_num = 8'($urandom);
            dev_num = 5'($urandom);
            fn_num  = 3'($urandom);
            run_pkt(16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom), 7'($urandom),
                    1'($urandom), {$urandom, $urandom}, 1, 1'b0);
        end

        // Drive abort_count into saturation.
        for (int i = 0; i < 256; i++) begin
            @(posedge trn_clk); #1;
            bus_if.req_valid = 1'b1;
            @(posedge trn_clk); #1;
            bus_if.req_valid    = 1'b0;
            bus_if.trn_lnk_up_n = 1'b1;
            @(posedge trn_clk); #1;
            bus_if.trn_lnk_up_n = 1'b0;
        end
        exp_abort = (exp_abort + 256 > 255) ? 255 : exp_abort + 256;
        @(negedge trn_clk);
        check("abort_saturate", abort_count, exp_abort[7:0]);
        check("abort_cpl_same", cpl_count, exp_cpl[15:0]);

        // Reset during BEAT0 discards the packet at once.
        start_req(16'h5555, 8'h10, 3'd0, 2'd0, 7'h00, 1'b1, 64'h0);
        bus_if.trn_tdst_rdy_n = 1'b1;
        #2;
        trn_reset = 1'b1;
        #1;
        check("rst_mid_flags", {bus_if.trn_tsrc_rdy_n, bus_if.trn_tsof_n, bus_if.trn_td}, {2'b11, 64'h0});
        check("rst_mid_counters", {cpl_count, abort_count}, 24'h0);
        exp_cpl   = 0;
        exp_abort = 0;
        @(posedge trn_clk); #1;
        trn_reset = 1'b0;
        run_pkt(16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 1'b0, {32'h0, 32'hDEADBEEF}, 0, 1'b0);
        check("post_rst_cpl", cpl_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_cpl_tx.md
PCIE_CPL_TX -- requirements
Module: pcie_cpl_tx

Interface
REQ-001 SHALL have ports: trn_clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have ports: trn_reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: trn_lnk_up_n  in  1  link up, active-low.
REQ-004 SHALL have ports: trn_tbuf_av  in  6  endpoint transmit buffers available.
REQ-005 SHALL have ports: trn_tdst_rdy_n  in  1  endpoint accepts beat, active-low.
REQ-006 SHALL have ports: cfg_bus_number  in  8; cfg_device_number  in  5; cfg_function_number  in  3.
REQ-007 SHALL have ports: req_valid  in  1; req_ready  out  1  read-completion request handshake.
REQ-008 SHALL have ports: req_rid  in  16  requester ID; req_tag  in  8; req_tc  in  3; req_attr  in  2; req_lower_addr  in  7; req_len2  in  1 (0 = 1 DW, 1 = 2 DW); req_data  in  64 (DW0 = [31:0], DW1 = [63:32]).
REQ-009 SHALL have ports: trn_td  out  64; trn_trem_n  out  1; trn_tsof_n  out  1; trn_teof_n  out  1; trn_tsrc_rdy_n  out  1.
REQ-010 SHALL have ports: trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n  out  1  each, constant 1.
REQ-011 SHALL have ports: cpl_count  out  16  completions sent; abort_count  out  8  packets aborted.

Function
REQ-012 SHALL implement FSM states IDLE, BEAT0, BEAT1, BEAT2.
REQ-013 req_ready SHALL be 1 only in IDLE with trn_lnk_up_n=0 and trn_tbuf_av!=0; combinational from registered state and inputs.
REQ-014 On req_valid&req_ready: all req_* fields and the completer ID {bus,dev,fn} SHALL be captured; next cycle state=BEAT0, trn_tsrc_rdy_n=0 (latency 1 cycle).
REQ-015 A beat SHALL transfer only in a cycle where trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0; otherwise all trn_* outputs SHALL hold.
REQ-016 All trn_* outputs SHALL be registered.
REQ-017 DW0 SHALL be {1'b0, fmt 2'b10, type 5'b01010, 1'b0, tc, 4'b0, TD 0, EP 0, attr, 2'b00, length 10 bits = 1 or 2}.
REQ-018 DW1 SHALL be {completer_id 16, status 3'b000, BCM 0, byte_count 12 = 4 or 8}.
REQ-019 DW2 SHALL be {req_rid, req_tag, 1'b0, req_lower_addr}.
REQ-020 BEAT0 SHALL drive trn_td={DW0,DW1}, tsof_n=0, teof_n=1, trem_n=0.
REQ-021 BEAT1 SHALL drive trn_td={DW2,data DW0}, tsof_n=1, trem_n=0; teof_n=0 when len=1, else 1.
REQ-022 BEAT2 (len=2 only) SHALL drive trn_td={data DW1,32'h0}, tsof_n=1, teof_n=0, trem_n=1.
REQ-023 On transfer of the EOF beat: state->IDLE, trn_tsrc_rdy_n=1, and cpl_count+1 (wraps 16'hFFFF->0).
REQ-024 Minimum spacing between packets SHALL be one idle cycle (no back-to-back SOF).
REQ-025 If trn_lnk_up_n=1 in any BEAT state: next cycle state=IDLE, tsrc_rdy_n=1, and abort_count+1, saturating at 8'hFF; cpl_count unchanged.
REQ-026 A link-down abort SHALL take precedence over a simultaneous beat transfer.
REQ-027 trn_tbuf_av SHALL be sampled only in IDLE; a later change SHALL NOT stall an in-progress packet.
REQ-028 In IDLE, trn_td SHALL hold its last value; tsof_n=teof_n=1.

Reset
REQ-029 While trn_reset=1: state=IDLE, trn_tsrc_rdy_n=1, tsof_n=1, teof_n=1, trem_n=0, trn_td=0, cpl_count=0, abort_count=0, req_ready=0 until reset deasserts.
REQ-030 Reset mid-packet SHALL discard the packet immediately without incrementing either counter.

Verification
REQ-031 1-DW request: rid=16'h0100, tag=8'h05, lower_addr=7'h04, data=32'hDEADBEEF, bus/dev/fn=1/0/0, tdst_rdy_n=0 -> 2 beats:
  - beat 0 = 64'h4A000001_01000004
  - beat 1 = 64'h01000504_DEADBEEF, teof_n=0, trem_n=0
  - cpl_count=1
REQ-032 2-DW request, data=64'h11112222_33334444 -> 3 beats:
  - beat 0 length=2, byte_count=8
  - beat 1 low DW = 32'h33334444
  - beat 2 = 64'h11112222_00000000 with trem_n=1
REQ-033 Hold tdst_rdy_n=1 for 5 cycles during BEAT1 -> trn_td and all flags stable; packet completes after release.
REQ-034 Deassert link (trn_lnk_up_n=1) during BEAT1 -> IDLE next cycle, abort_count=1, cpl_count unchanged, req_ready=0.
REQ-035 trn_tbuf_av=0 with req_valid=1 -> req_ready=0, no SOF; set trn_tbuf_av=6'h01 -> accept, SOF next cycle.
REQ-036 Assert trn_reset during BEAT0 -> tsrc_rdy_n=1 immediately, counters 0; the next request after reset completes normally.
